// File: rtl/z_wave_gen.sv
// z_wave_gen: sine-wave sample source for the impedance-measurement SPI master.
// A phase-accumulator DDS with a quarter-wave LUT drives the master's d_in1/d_in2
// bus. Framing follows the master's CS_b: after a trigger, HDR_FRAMES header frames
// are skipped, then one sample is consumed per data frame. There are 16 electrode
// pairs of (stim_cycles_per_elctrd+1) frames each.
//
// Ports:
//   CLK                    in   system clock (shared with the SPI master)
//   RST                    in   asynchronous, active-high reset
//   z_meas_trig            in   start pulse; ignored while busy
//   stim_cycles_per_elctrd in   frames per electrode minus 1 (latched on trigger)
//   phase_inc              in   phase step per data frame (latched on trigger)
//   phase_off2             in   d_in2 phase lead over d_in1 (latched on trigger)
//   amp_shift              in   magnitude attenuation shift (latched on trigger)
//   cs_b                   in   CS_b from the SPI master; a rising edge ends a frame
//   d_in1 / d_in2          out  channel-0 / channel-16 samples, offset binary
//   busy                   out  high from trigger acceptance to the last data frame
//   elctrd_n               out  current electrode pair index, 0..15
module z_wave_gen #(
    parameter int PHASE_W      = 24,
    parameter int LUT_AW       = 8,
    parameter int HDR_FRAMES   = 4,
    parameter int PHASE_RST_EL = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               z_meas_trig,
    input  logic [15:0]        stim_cycles_per_elctrd,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic [PHASE_W-1:0] phase_off2,
    input  logic [3:0]         amp_shift,
    input  logic               cs_b,
    output logic [15:0]        d_in1,
    output logic [15:0]        d_in2,
    output logic               busy,
    output logic [3:0]         elctrd_n
);

    localparam int HDR_W = $clog2(HDR_FRAMES + 1);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_RUN} state_t;

    // Quarter-wave entry k = round(32767 * sin(pi/2 * (k+0.5) / 2^LUT_AW)),
    // evaluated at elaboration with a Taylor series (ample precision in double).
    function automatic logic [14:0] lut_val(input int k);
        real x, term, acc;
        int  v;
        x    = 3.14159265358979323846 / 2.0 * ($itor(k) + 0.5) / $itor(2 ** LUT_AW);
        term = x;
        acc  = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / $itor((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        v = $rtoi(32767.0 * acc + 0.5);
        return v[14:0];
    endfunction

    // Odd quadrants walk the quarter wave backwards.
    function automatic logic [LUT_AW-1:0] lut_addr(input logic [PHASE_W-1:0] p);
        logic [LUT_AW-1:0] a;
        a = p[PHASE_W-3 -: LUT_AW];
        return p[PHASE_W-2] ? ~a : a;
    endfunction

    // NOTE: the LUT is a constant ROM; it has no state and needs no reset.
    logic [14:0] lut_rom [2**LUT_AW];
    for (genvar k = 0; k < 2 ** LUT_AW; k++) begin : g_lut
        localparam logic [14:0] VAL = lut_val(k);
        assign lut_rom[k] = VAL;
    end

    state_t             state_q, state_d;
    logic               cs_b_q;
    logic [HDR_W-1:0]   hdr_cnt_q, hdr_cnt_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic [3:0]         elctrd_q, elctrd_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [15:0]        stim_q, stim_d;
    logic [PHASE_W-1:0] inc_q, inc_d;
    logic [PHASE_W-1:0] off2_q, off2_d;
    logic [3:0]         amp_q, amp_d;
    logic               frame_edge;

    assign frame_edge = cs_b & ~cs_b_q;

    // NOTE: every next-state signal gets its hold value first, so no path through
    // this block leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        frame_cnt_d = frame_cnt_q;
        elctrd_d    = elctrd_q;
        phase_d     = phase_q;
        stim_d      = stim_q;
        inc_d       = inc_q;
        off2_d      = off2_q;
        amp_d       = amp_q;
        case (state_q)
            S_IDLE: begin
                // A trigger takes priority over a coincident frame edge.
                if (z_meas_trig) begin
                    stim_d      = stim_cycles_per_elctrd;
                    inc_d       = phase_inc;
                    off2_d      = phase_off2;
                    amp_d       = amp_shift;
                    phase_d     = '0;
                    hdr_cnt_d   = '0;
                    frame_cnt_d = '0;
                    elctrd_d    = '0;
                    state_d     = S_HDR;
                end
            end
            S_HDR: begin
                if (frame_edge) begin
                    hdr_cnt_d = hdr_cnt_q + 1'b1;
                    if (hdr_cnt_q == HDR_W'(HDR_FRAMES - 1)) state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (frame_edge) begin
                    if (frame_cnt_q == stim_q) begin
                        frame_cnt_d = '0;
                        if (elctrd_q == 4'd15) begin
                            state_d = S_IDLE;
                        end else begin
                            elctrd_d = elctrd_q + 4'd1;
                            phase_d  = (PHASE_RST_EL != 0) ? '0 : phase_q + inc_q;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        phase_d     = phase_q + inc_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; RST clears it asynchronously.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cs_b_q      <= 1'b1;
            hdr_cnt_q   <= '0;
            frame_cnt_q <= '0;
            elctrd_q    <= '0;
            phase_q     <= '0;
            stim_q      <= '0;
            inc_q       <= '0;
            off2_q      <= '0;
            amp_q       <= '0;
        end else begin
            state_q     <= state_d;
            cs_b_q      <= cs_b;
            hdr_cnt_q   <= hdr_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            elctrd_q    <= elctrd_d;
            phase_q     <= phase_d;
            stim_q      <= stim_d;
            inc_q       <= inc_d;
            off2_q      <= off2_d;
            amp_q       <= amp_d;
        end
    end

    // Sample pipeline: stage 1 registers the attenuated LUT magnitude and sign,
    // stage 2 registers both offset-binary outputs on the same edge. live_q
    // marks stage 1 as holding a sample computed outside IDLE, so a stale
    // stage-1 value never reaches the outputs right after a trigger.
    logic [14:0] m1_q, m2_q;
    logic        neg1_q, neg2_q, live_q;
    logic [15:0] d1_q, d2_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            m1_q   <= '0;
            m2_q   <= '0;
            neg1_q <= 1'b0;
            neg2_q <= 1'b0;
            live_q <= 1'b0;
            d1_q   <= 16'h8000;
            d2_q   <= 16'h8000;
        end else begin
            m1_q   <= lut_rom[lut_addr(phase_q)] >> amp_q;
            m2_q   <= lut_rom[lut_addr(phase_q + off2_q)] >> amp_q;
            neg1_q <= phase_q[PHASE_W-1];
            neg2_q <= (phase_q + off2_q) >= (PHASE_W'(1) << (PHASE_W - 1));
            live_q <= (state_q != S_IDLE);
            if (live_q && (state_q != S_IDLE)) begin
                d1_q <= neg1_q ? 16'h8000 - {1'b0, m1_q} : 16'h8000 + {1'b0, m1_q};
                d2_q <= neg2_q ? 16'h8000 - {1'b0, m2_q} : 16'h8000 + {1'b0, m2_q};
            end else begin
                d1_q <= 16'h8000;
                d2_q <= 16'h8000;
            end
        end
    end

    assign d_in1    = d1_q;
    assign d_in2    = d2_q;
    assign busy     = (state_q != S_IDLE);
    assign elctrd_n = elctrd_q;

endmodule
